// File: rtl/spi_slave_responder.sv
// SPI slave (CPHA=0, CPOL selectable) with a valid/ready word interface on the pclk side.
// Build macro SPI_RESPONDER_LSB_FIRST_EN switches both transmit and receive to LSB first.
module spi_slave_responder #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter bit                    CPOL       = 1'b0,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi0,
    output logic                  miso0,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    state_e                  state_q, state_d;
    logic                    sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
    logic                    cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_prev_q, cs_prev_d;
    logic                    mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic [1:0]              prime_q, prime_d;
    logic                    armed_q, armed_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0]   tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-2:0]   rx_sr_q, rx_sr_d;
    logic                    miso_q, miso_d;
    logic                    miso_oe_q, miso_oe_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    frame_err_q, frame_err_d;

    logic                    sclk_lead, sclk_trail, cs_fall, word_done;
    logic [DATA_WIDTH-1:0]   load_word, new_word;
    logic [DATA_WIDTH-2:0]   rx_shifted;

    assign sclk_lead  = (sclk_prev_q == CPOL) && (sclk_s2_q != CPOL);
    assign sclk_trail = (sclk_prev_q != CPOL) && (sclk_s2_q == CPOL);
    // A fall only counts once cs has been seen high after reset, so a frame
    // already in progress when reset releases is ignored.
    assign cs_fall    = armed_q && cs_prev_q && !cs_s2_q;
    assign load_word  = tx_valid ? tx_data : TX_IDLE;

`ifdef SPI_RESPONDER_LSB_FIRST_EN
    assign rx_shifted = {mosi_s2_q, rx_sr_q[DATA_WIDTH-2:1]};
    assign new_word   = {mosi_s2_q, rx_sr_q};
`else
    assign rx_shifted = {rx_sr_q[DATA_WIDTH-3:0], mosi_s2_q};
    assign new_word   = {rx_sr_q, mosi_s2_q};
`endif

    always_comb begin
        // NOTE: every _d takes its _q (or idle value) first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        sclk_s1_d   = sclk;
        sclk_s2_d   = sclk_s1_q;
        sclk_prev_d = sclk_s2_q;
        cs_s1_d     = cs;
        cs_s2_d     = cs_s1_q;
        cs_prev_d   = cs_s2_q;
        mosi_s1_d   = mosi0;
        mosi_s2_d   = mosi_s1_q;
        prime_d     = {prime_q[0], 1'b1};
        armed_d     = armed_q | (prime_q[1] & cs_s2_q);
        bit_cnt_d   = bit_cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = LOAD;
                    miso_oe_d = 1'b1;
                end
            end
            LOAD: begin
                state_d   = SHIFT;
                bit_cnt_d = '0;
`ifdef SPI_RESPONDER_LSB_FIRST_EN
                miso_d    = load_word[0];
                tx_sr_d   = load_word[DATA_WIDTH-1:1];
`else
                miso_d    = load_word[DATA_WIDTH-1];
                tx_sr_d   = load_word[DATA_WIDTH-2:0];
`endif
            end
            SHIFT: begin
                if (cs_s2_q) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    miso_oe_d   = 1'b0;
                end else begin
                    if (sclk_lead) begin
                        rx_sr_d   = rx_shifted;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d   = DONE;
                            word_done = 1'b1;
                        end
                    end
                    if (sclk_trail) begin
`ifdef SPI_RESPONDER_LSB_FIRST_EN
                        miso_d  = tx_sr_q[0];
                        tx_sr_d = {1'b0, tx_sr_q[DATA_WIDTH-2:1]};
`else
                        miso_d  = tx_sr_q[DATA_WIDTH-2];
                        tx_sr_d = {tx_sr_q[DATA_WIDTH-3:0], 1'b0};
`endif
                    end
                end
            end
            DONE: begin
                if (cs_s2_q) begin
                    state_d   = IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing word always loads; it only counts as lost if the held one was not taken.
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        overrun_d  = overrun_q & ~overrun_clr;
        if (word_done) begin
            rx_data_d  = new_word;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        // NOTE: non-blocking assignments only here, so every flop samples the pre-edge values.
        if (areset) begin
            state_q     <= IDLE;
            sclk_s1_q   <= CPOL;
            sclk_s2_q   <= CPOL;
            sclk_prev_q <= CPOL;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            prime_q     <= '0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_prev_q <= sclk_prev_d;
            cs_s1_q     <= cs_s1_d;
            cs_s2_q     <= cs_s2_d;
            cs_prev_q   <= cs_prev_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            prime_q     <= prime_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso0     = miso_q;
    assign miso_oe   = miso_oe_q;
    assign tx_ready  = (state_q == LOAD) && tx_valid;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: directed frames plus randomized frames
// compared against a word-level model of the receive/transmit behaviour.
module tb_spi_slave_responder;

    localparam int W    = 8;
    localparam bit CPOL = 1'b0;
    localparam int H    = 6;   // sclk half-period in pclk cycles
`ifdef SPI_RESPONDER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic         pclk = 1'b0;
    logic         areset = 1'b1;
    logic         sclk = CPOL;
    logic         cs = 1'b1;
    logic         mosi0 = 1'b0;
    logic         miso0, miso_oe;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic         overrun;
    logic         overrun_clr = 1'b0;
    logic         frame_err;

    int checks = 0;
    int failures = 0;
    int ready_total = 0;
    int ferr_total = 0;

    // Word-level expectation of the receive side
    logic         ex_valid = 1'b0;
    logic [W-1:0] ex_data = '0;
    logic         ex_ovr = 1'b0;

    spi_slave_responder #(.DATA_WIDTH(W), .CPOL(CPOL)) dut (
        .pclk(pclk), .areset(areset), .sclk(sclk), .cs(cs), .mosi0(mosi0),
        .miso0(miso0), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overrun(overrun), .overrun_clr(overrun_clr), .frame_err(frame_err)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (tx_ready) ready_total++;
        if (frame_err) ferr_total++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // i-th bit on the wire for word w
    function automatic logic ser_bit(input logic [W-1:0] w, input int i);
        return LSB_FIRST ? w[i] : w[W-1-i];
    endfunction

    // end_ctl: 0 none, 1 rx_ready pulse on the word-complete cycle, 2 overrun_clr pulse on it.
    // rst_at:  nonzero pulses areset before leading edge rst_at, with cs held low.
    task automatic frame(input string tag, input logic [W-1:0] word, input int n_lead,
                         input logic tv, input logic [W-1:0] td, input int end_ctl, input int rst_at);
        logic [W-1:0] txw;
        logic full, set_ovr, clr_ovr;
        int r0, f0;
        txw  = tv ? td : '1;
        full = (n_lead == W) && (rst_at == 0);
        r0 = ready_total;
        f0 = ferr_total;
        tx_valid = tv;
        tx_data  = td;
        @(negedge pclk);
        cs = 1'b0;
        mosi0 = ser_bit(word, 0);
        repeat (6) @(negedge pclk);
        for (int i = 0; i < n_lead; i++) begin
            if (rst_at != 0 && i == rst_at) begin
                areset = 1'b1;
                repeat (2) @(negedge pclk);
                areset = 1'b0;
            end
            mosi0 = ser_bit(word, i);
            repeat (H) @(negedge pclk);
            if (rst_at == 0) begin
                check({tag, " miso bit"}, miso0, ser_bit(txw, i));
                check({tag, " miso_oe active"}, miso_oe, 1'b1);
            end
            sclk = ~CPOL;
            if (i == W - 1 && end_ctl != 0) begin
                // Two flops of synchronizer, then the word completes on the following edge.
                repeat (2) @(negedge pclk);
                if (end_ctl == 1) rx_ready = 1'b1;
                else overrun_clr = 1'b1;
                @(negedge pclk);
                rx_ready = 1'b0;
                overrun_clr = 1'b0;
                repeat (H - 3) @(negedge pclk);
            end else begin
                repeat (H) @(negedge pclk);
            end
            sclk = CPOL;
        end
        repeat (H) @(negedge pclk);
        if (full) begin
            check({tag, " miso holds last"}, miso0, ser_bit(txw, W - 1));
            check({tag, " miso_oe in done"}, miso_oe, 1'b1);
        end
        cs = 1'b1;
        tx_valid = 1'b0;
        repeat (6) @(negedge pclk);

        if (full) begin
            set_ovr = ex_valid && (end_ctl != 1);
            clr_ovr = (end_ctl == 2);
            ex_ovr   = (ex_ovr && !clr_ovr) || set_ovr;
            ex_valid = 1'b1;
            ex_data  = word;
        end
        if (rst_at != 0) begin
            ex_valid = 1'b0;
            ex_data  = '0;
            ex_ovr   = 1'b0;
        end
        check({tag, " rx_valid"}, rx_valid, ex_valid);
        check({tag, " rx_data"}, rx_data, ex_data);
        check({tag, " overrun"}, overrun, ex_ovr);
        check({tag, " frame_err pulses"}, ferr_total - f0, (n_lead < W && rst_at == 0) ? 1 : 0);
        check({tag, " tx_ready pulses"}, ready_total - r0, tv ? 1 : 0);
        check({tag, " miso_oe idle"}, miso_oe, 1'b0);
        check({tag, " miso idle"}, miso0, 1'b0);
    endtask

    task automatic consume();
        @(negedge pclk);
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;
        ex_valid = 1'b0;
        check("consume rx_valid", rx_valid, ex_valid);
    endtask

    task automatic clear_overrun();
        @(negedge pclk);
        overrun_clr = 1'b1;
        @(negedge pclk);
        overrun_clr = 1'b0;
        ex_ovr = 1'b0;
        check("overrun_clr", overrun, ex_ovr);
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        check("reset miso0", miso0, 1'b0);
        check("reset miso_oe", miso_oe, 1'b0);
        check("reset tx_ready", tx_ready, 1'b0);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_data", rx_data, '0);
        check("reset overrun", overrun, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        areset = 1'b0;
        repeat (5) @(negedge pclk);

        frame("tx3C rxA5", 8'hA5, W, 1'b1, 8'h3C, 0, 0);
        consume();
        frame("tx idle", 8'h96, W, 1'b0, 8'h00, 0, 0);
        consume();

        frame("ovr first", 8'h11, W, 1'b0, 8'h00, 0, 0);
        frame("ovr second", 8'h22, W, 1'b1, 8'h81, 0, 0);
        clear_overrun();

        frame("ready at done", 8'h33, W, 1'b0, 8'h00, 1, 0);
        frame("set beats clr", 8'h44, W, 1'b1, 8'h5C, 2, 0);
        clear_overrun();

        frame("abort", 8'h77, 5, 1'b1, 8'hE1, 0, 0);
        consume();
        frame("after abort", 8'h5A, W, 1'b1, 8'h0F, 0, 0);
        consume();

        frame("serial 10100101", 8'hA5, W, 1'b0, 8'h00, 0, 0);
        check("serial 10100101 word", rx_data, 8'hA5);
        consume();

        frame("reset mid frame", 8'h99, W, 1'b0, 8'h00, 0, 3);
        frame("after reset", 8'hC3, W, 1'b1, 8'h3C, 0, 0);

        for (int n = 0; n < 12; n++) begin
            logic [W-1:0] w, d;
            int nl;
            w  = W'($urandom);
            d  = W'($urandom);
            nl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : W;
            frame("random", w, nl, 1'($urandom), d, 0, 0);
            if ($urandom_range(0, 1) == 1) consume();
            if (ex_ovr && $urandom_range(0, 1) == 1) clear_overrun();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
